// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI mode-0 shift engine: FSM states, clock polarity and default sizes.
package spi_shift_engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  localparam logic SPI_CPOL        = 1'b0;
  localparam int   DEFAULT_DATA_W  = 8;
  localparam int   DEFAULT_CS_HOLD = 2;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Bundle of host handshake, rategen strobes and SPI pins around the shift engine.
interface spi_shift_engine_if #(
  parameter int DATA_W = 8
);

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              rate_en;
  logic              rate_sck;
  logic              rate_sample;
  logic              rate_update;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic              cs_n;

  // The engine serves transfer requests, so it is the slave side of this bundle.
  modport slave (
    input  start, tx_data, rate_sck, rate_sample, rate_update, miso,
    output busy, done, rx_data, rate_en, sck, mosi, cs_n
  );

  modport master (
    output start, tx_data, rate_sck, rate_sample, rate_update, miso,
    input  busy, done, rx_data, rate_en, sck, mosi, cs_n
  );

endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 master word engine driven by the 16:1 rategen strobes; frames each word with cs_n.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CS_HOLD = DEFAULT_CS_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  spi_shift_engine_if.slave  bus
);

  localparam int CW = cnt_width(DATA_W);
  localparam int HW = cnt_width(CS_HOLD);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [CW-1:0]     bit_q, bit_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rate_en_q, rate_en_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] tx_shifted;

  assign tx_shifted = tx_q << 1;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_d     = bit_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    rate_en_d = rate_en_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d      = bus.tx_data;
          rx_d      = '0;
          bit_d     = '0;
          mosi_d    = bus.tx_data[DATA_W-1];
          cs_n_d    = 1'b0;
          rate_en_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = LEAD;
        end
      end

      // The first update is only the launch edge; MSB is already on mosi.
      LEAD: begin
        if (bus.rate_update) begin
          state_d = XFER;
        end
      end

      // Sample has priority, so a coincident update never shifts.
      XFER: begin
        if (bus.rate_sample) begin
          rx_d = DATA_W'({rx_q, bus.miso});
          if (bit_q != CW'(DATA_W)) begin
            bit_d = bit_q + 1'b1;
          end
        end else if (bus.rate_update) begin
          if (bit_q == CW'(DATA_W)) begin
            rate_en_d = 1'b0;
            hold_d    = '0;
            state_d   = TRAIL;
          end else begin
            tx_d   = tx_shifted;
            mosi_d = tx_shifted[DATA_W-1];
          end
        end
      end

      TRAIL: begin
        if (hold_q == HW'(CS_HOLD - 1)) begin
          cs_n_d    = 1'b1;
          rx_data_d = rx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
          bit_d     = '0;
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      rate_en_q <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      rate_en_q <= rate_en_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  // SCK is the only combinational output: rategen's clock gated to the data phase.
  assign bus.sck     = SPI_CPOL ^ (bus.rate_sck & (state_q == XFER));
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rate_en = rate_en_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;

endmodule
